// File: rtl/regfile_mp.sv
// Multi-port register file with optional write-to-read bypass, optional hardwired x0,
// and a per-register pending-write scoreboard (issue sets, writeback clears, flush wipes).
module regfile_mp #(
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 32,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1,
   localparam int AW      = $clog2(NUM_REGS)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NUM_RD*AW-1:0]   rd_addr,
   output logic [NUM_RD*XLEN-1:0] rd_data,
   output logic [NUM_RD-1:0]      rd_busy,
   input  logic [NUM_WR-1:0]      wr_en,
   input  logic [NUM_WR*AW-1:0]   wr_addr,
   input  logic [NUM_WR*XLEN-1:0] wr_data,
   input  logic                   iss_en,
   input  logic [AW-1:0]          iss_addr,
   input  logic                   flush,
   output logic [NUM_REGS-1:0]    busy_vec
);

   logic [XLEN-1:0]     regs_q [NUM_REGS];
   logic [XLEN-1:0]     regs_d [NUM_REGS];
   logic [NUM_REGS-1:0] pend_q;
   logic [NUM_REGS-1:0] pend_d;

   // Ascending port order lets the highest-index writer overwrite lower ones.
   always_comb begin
      regs_d = regs_q;
      for (int w = 0; w < NUM_WR; w++) begin
         if (wr_en[w] && !((ZERO_REG != 0) && (wr_addr[w*AW +: AW] == '0))) begin
            regs_d[wr_addr[w*AW +: AW]] = wr_data[w*XLEN +: XLEN];
         end
      end
   end

   // Issue is applied after writeback clears so a new producer supersedes the old one.
   always_comb begin
      pend_d = pend_q;
      if (flush) begin
         pend_d = '0;
      end else begin
         for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w]) begin
               pend_d[wr_addr[w*AW +: AW]] = 1'b0;
            end
         end
         if (iss_en) begin
            pend_d[iss_addr] = 1'b1;
         end
      end
      if (ZERO_REG != 0) begin
         pend_d[0] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs_q[r] <= '0;
         end
         pend_q <= '0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs_q[r] <= regs_d[r];
         end
         pend_q <= pend_d;
      end
   end

   // Later assignments take precedence: bypass overrides storage, x0 overrides both.
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         rd_data[k*XLEN +: XLEN] = regs_q[rd_addr[k*AW +: AW]];
         rd_busy[k]              = pend_q[rd_addr[k*AW +: AW]];
         if (BYPASS != 0) begin
            for (int w = 0; w < NUM_WR; w++) begin
               if (wr_en[w] && (wr_addr[w*AW +: AW] == rd_addr[k*AW +: AW])) begin
                  rd_data[k*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
                  rd_busy[k]              = 1'b0;
               end
            end
         end
         if ((ZERO_REG != 0) && (rd_addr[k*AW +: AW] == '0)) begin
            rd_data[k*XLEN +: XLEN] = '0;
            rd_busy[k]              = 1'b0;
         end
      end
   end

   assign busy_vec = pend_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (bypass+zero-reg, and plain) share all inputs and are
// compared against a behavioural model, a directed vector table and hand-written sequences.
module tb_regfile_mp;

   localparam int XLEN = 32;
   localparam int NR   = 32;
   localparam int AW   = 5;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [9:0]    rd_addr;
   logic [1:0]    wr_en;
   logic [9:0]    wr_addr;
   logic [63:0]   wr_data;
   logic          iss_en;
   logic [4:0]    iss_addr;
   logic          flush;

   logic [63:0]   rd_data_a, rd_data_b;
   logic [1:0]    rd_busy_a, rd_busy_b;
   logic [31:0]   busy_vec_a, busy_vec_b;

   int total = 0;
   int bad   = 0;

   logic [31:0] mref [2][NR];
   logic        pref [2][NR];

   always #5 clk = ~clk;

   regfile_mp #(.BYPASS(1), .ZERO_REG(1)) dut_a (
      .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data_a),
      .rd_busy(rd_busy_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy_vec(busy_vec_a)
   );

   regfile_mp #(.BYPASS(0), .ZERO_REG(0)) dut_b (
      .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data_b),
      .rd_busy(rd_busy_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy_vec(busy_vec_b)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int c = 0; c < 2; c++)
         for (int r = 0; r < NR; r++) begin
            mref[c][r] = '0;
            pref[c][r] = 1'b0;
         end
   endtask

   // Config 0: bypass + hardwired x0.  Config 1: neither.
   task automatic model_rd(input int c, input logic [4:0] a, output logic [31:0] d, output logic b);
      bit done = 0;
      d = mref[c][a];
      b = pref[c][a];
      if (c == 0) begin
         for (int w = 1; w >= 0; w--)
            if (!done && wr_en[w] && wr_addr[w*AW +: AW] == a) begin
               d = wr_data[w*XLEN +: XLEN];
               b = 1'b0;
               done = 1;
            end
         if (a == 0) begin
            d = '0;
            b = 1'b0;
         end
      end
   endtask

   task automatic model_commit();
      logic [4:0] a;
      for (int c = 0; c < 2; c++) begin
         for (int w = 0; w < 2; w++) begin
            a = wr_addr[w*AW +: AW];
            if (wr_en[w] && !(c == 0 && a == 0)) mref[c][a] = wr_data[w*XLEN +: XLEN];
         end
         if (flush) begin
            for (int r = 0; r < NR; r++) pref[c][r] = 1'b0;
         end else begin
            for (int w = 0; w < 2; w++)
               if (wr_en[w]) pref[c][wr_addr[w*AW +: AW]] = 1'b0;
            if (iss_en) pref[c][iss_addr] = 1'b1;
         end
         if (c == 0) pref[c][0] = 1'b0;
      end
   endtask

   task automatic check_all();
      logic [31:0] d, bv;
      logic        b;
      for (int c = 0; c < 2; c++) begin
         for (int k = 0; k < 2; k++) begin
            model_rd(c, rd_addr[k*AW +: AW], d, b);
            chk($sformatf("cfg%0d_rd_data%0d", c, k),
                (c == 0) ? rd_data_a[k*XLEN +: XLEN] : rd_data_b[k*XLEN +: XLEN], d);
            chk($sformatf("cfg%0d_rd_busy%0d", c, k),
                {31'b0, (c == 0) ? rd_busy_a[k] : rd_busy_b[k]}, {31'b0, b});
         end
         for (int r = 0; r < NR; r++) bv[r] = pref[c][r];
         chk($sformatf("cfg%0d_busy_vec", c), (c == 0) ? busy_vec_a : busy_vec_b, bv);
      end
   endtask

   task automatic idle_inputs();
      wr_en = '0; wr_addr = '0; wr_data = '0;
      iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
   endtask

   // Inputs are set after a falling edge; this commits them on the next rising edge.
   task automatic tick();
      @(posedge clk);
      if (reset_n) model_commit();
      @(negedge clk);
   endtask

   typedef struct {
      logic [1:0]  we;
      logic [4:0]  wa0;
      logic [31:0] wd0;
      logic [4:0]  wa1;
      logic [31:0] wd1;
      logic        ie;
      logic [4:0]  ia;
      logic        fl;
      logic [4:0]  ra0;
      logic [31:0] a_rd0;
      logic        a_bz0;
      logic [31:0] a_bv;
      logic [31:0] b_rd0;
      logic        b_bz0;
      logic [31:0] b_bv;
   } vec_t;

   vec_t vt [17];

   initial begin
      vt[0]  = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd5,
                 32'hDEADBEEF, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0};
      vt[1]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd5,
                 32'hDEADBEEF, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 32'h0};
      vt[2]  = '{2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd0, 1'b0, 5'd7,
                 32'h22, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0};
      vt[3]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd7,
                 32'h22, 1'b0, 32'h0, 32'h22, 1'b0, 32'h0};
      vt[4]  = '{2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0,
                 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0};
      vt[5]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0,
                 32'h0, 1'b0, 32'h0, 32'hFFFFFFFF, 1'b1, 32'h1};
      vt[6]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd9,
                 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h1};
      vt[7]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd9,
                 32'h0, 1'b1, 32'h200, 32'h0, 1'b1, 32'h201};
      vt[8]  = '{2'b01, 5'd9, 32'h42, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd9,
                 32'h42, 1'b0, 32'h200, 32'h0, 1'b1, 32'h201};
      vt[9]  = '{2'b01, 5'd9, 32'h55, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd9,
                 32'h55, 1'b0, 32'h200, 32'h42, 1'b1, 32'h201};
      vt[10] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd9,
                 32'h55, 1'b0, 32'h0, 32'h55, 1'b0, 32'h1};
      vt[11] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd3,
                 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h1};
      vt[12] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 5'd3,
                 32'h0, 1'b1, 32'h8, 32'h0, 1'b1, 32'h9};
      vt[13] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd12, 1'b0, 5'd4,
                 32'h0, 1'b1, 32'h18, 32'h0, 1'b1, 32'h19};
      vt[14] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd20, 1'b1, 5'd12,
                 32'h0, 1'b1, 32'h1018, 32'h0, 1'b1, 32'h1019};
      vt[15] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd5,
                 32'hDEADBEEF, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 32'h0};
      vt[16] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd7,
                 32'h22, 1'b0, 32'h0, 32'h22, 1'b0, 32'h0};

      // Reset with writes attempted; nothing may land.
      reset_n = 1'b0;
      idle_inputs();
      rd_addr = '0;
      wr_en   = 2'b11;
      wr_addr = {5'd6, 5'd5};
      wr_data = {32'h12345678, 32'hCAFEF00D};
      model_clear();
      tick();
      tick();
      idle_inputs();
      reset_n = 1'b1;
      for (int r = 0; r < NR; r++) begin
         rd_addr = {5'(NR - 1 - r), 5'(r)};
         #1 check_all();
      end
      @(negedge clk);

      // Directed table.
      for (int i = 0; i < 17; i++) begin
         idle_inputs();
         wr_en = vt[i].we;
         wr_addr = {vt[i].wa1, vt[i].wa0};
         wr_data = {vt[i].wd1, vt[i].wd0};
         iss_en = vt[i].ie; iss_addr = vt[i].ia; flush = vt[i].fl;
         rd_addr = {5'd9, vt[i].ra0};
         #1;
         chk($sformatf("vec%0d_a_rd0", i), rd_data_a[31:0], vt[i].a_rd0);
         chk($sformatf("vec%0d_a_busy0", i), {31'b0, rd_busy_a[0]}, {31'b0, vt[i].a_bz0});
         chk($sformatf("vec%0d_a_bv", i), busy_vec_a, vt[i].a_bv);
         chk($sformatf("vec%0d_b_rd0", i), rd_data_b[31:0], vt[i].b_rd0);
         chk($sformatf("vec%0d_b_busy0", i), {31'b0, rd_busy_b[0]}, {31'b0, vt[i].b_bz0});
         chk($sformatf("vec%0d_b_bv", i), busy_vec_b, vt[i].b_bv);
         check_all();
         tick();
      end

      // Asynchronous reset mid-sequence: clears without a clock edge.
      idle_inputs();
      wr_en = 2'b01; wr_addr = {5'd0, 5'd6}; wr_data = {32'h0, 32'h0000ABCD};
      iss_en = 1'b1; iss_addr = 5'd3;
      tick();
      idle_inputs();
      rd_addr = {5'd7, 5'd6};
      #1;
      chk("pre_areset_rd6", rd_data_a[31:0], 32'h0000ABCD);
      chk("pre_areset_bv", busy_vec_a, 32'h8);
      #1 reset_n = 1'b0;
      model_clear();
      #1;
      chk("areset_rd6", rd_data_a[31:0], 32'h0);
      chk("areset_rd7", rd_data_a[63:32], 32'h0);
      chk("areset_bv_a", busy_vec_a, 32'h0);
      chk("areset_bv_b", busy_vec_b, 32'h0);
      check_all();
      @(negedge clk);
      reset_n = 1'b1;

      // Randomised traffic against the model; a narrow address window forces collisions.
      for (int i = 0; i < 400; i++) begin
         bit narrow;
         narrow   = ($urandom_range(0, 1) == 1);
         wr_en    = 2'($urandom_range(0, 3));
         wr_addr  = narrow ? {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))}
                           : 10'($urandom);
         wr_data  = {$urandom, $urandom};
         iss_en   = ($urandom_range(0, 1) == 1);
         iss_addr = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
         flush    = ($urandom_range(0, 15) == 0);
         rd_addr  = narrow ? {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))}
                           : 10'($urandom);
         #1 check_all();
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
